// File: rtl/soc_textbuf_pkg.sv
// Shared types and helpers for the text-mode character/attribute buffer.
package soc_textbuf_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Read latency of both ports in clock cycles.
  function automatic int rd_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/soc_textbuf_ram.sv
// Inferred dual-port RAM: port A read/write with byte enables, port B read-only,
// old data returned on a mixed-port collision, optional output register.
module soc_textbuf_ram
  import soc_textbuf_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int OUT_REG = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      a_we,
  input  logic                      a_re,
  input  logic [be_w(DATA_W)-1:0]   a_be,
  input  logic [ADDR_W-1:0]         a_addr,
  input  logic [DATA_W-1:0]         a_wdata,
  output logic [DATA_W-1:0]         a_rdata,
  input  logic                      b_en,
  input  logic [ADDR_W-1:0]         b_addr,
  output logic [DATA_W-1:0]         b_rdata
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [IDX_W-1:0]  a_idx;
  logic [IDX_W-1:0]  b_idx;

  // Callers keep addresses below DEPTH; the index is only as wide as the array needs.
  assign a_idx = a_addr[IDX_W-1:0];
  assign b_idx = b_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (a_we && a_be[i]) mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
    if (a_re) a_q <= mem[a_idx];
  end

  // Non-blocking read of the pre-edge array contents gives OLD_DATA on collision.
  always_ff @(posedge clk) begin
    if (b_en) b_q <= mem[b_idx];
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] a_o;
      logic [DATA_W-1:0] b_o;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          a_o <= '0;
          b_o <= '0;
        end else begin
          a_o <= a_q;
          if (b_en) b_o <= b_q;
        end
      end
      assign a_rdata = a_o;
      assign b_rdata = b_o;
    end else begin : g_noreg
      logic unused_rst;
      assign unused_rst = reset_n;
      assign a_rdata    = a_q;
      assign b_rdata    = b_q;
    end
  endgenerate

endmodule

// File: rtl/soc_textbuf_dpram.sv
// Text-mode buffer top: Avalon-MM port A, scanout port B, and a hardware fill
// engine that shares port A's write path.
module soc_textbuf_dpram
  import soc_textbuf_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int OUT_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic                     a_chipselect,
  input  logic                     a_read,
  input  logic                     a_write,
  input  logic [be_w(DATA_W)-1:0]  a_byteenable,
  input  logic [DATA_W-1:0]        a_writedata,
  output logic [DATA_W-1:0]        a_readdata,
  output logic                     a_readdatavalid,
  output logic                     a_waitrequest,
  input  logic [ADDR_W-1:0]        b_address,
  input  logic                     b_clken,
  output logic [DATA_W-1:0]        b_readdata,
  input  logic                     fill_start,
  input  logic [DATA_W-1:0]        fill_value,
  output logic                     fill_busy,
  output logic                     fill_done,
  output fill_state_t              fill_state
);

  localparam int LAT     = rd_latency(OUT_REG);
  localparam int ADDR_WP = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = ADDR_WP'(DEPTH);

  fill_state_t       state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill_val;
  logic              fill_run;
  logic              a_in_range, b_in_range;
  logic              a_accept, a_wr, a_rd;
  logic [LAT-1:0]    rvalid_pipe, roor_pipe, boor_pipe;

  logic                    ram_we, ram_re;
  logic [be_w(DATA_W)-1:0] ram_be;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata, ram_a_rdata, ram_b_rdata;

  assign fill_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FILL_IDLE;
      cnt      <= '0;
      fill_val <= '0;
    end else begin
      state <= state_nx;
      if (state == FILL_IDLE && fill_start) begin
        cnt      <= '0;
        fill_val <= fill_value;
      end else if (state == FILL_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    case (state)
      FILL_IDLE: if (fill_start) state_nx = FILL_RUN;
      FILL_RUN: begin
        fill_busy = 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state_nx = FILL_DONE;
      end
      FILL_DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_nx  = FILL_IDLE;
      end
      default: state_nx = FILL_IDLE;
    endcase
  end

  // Handshake: port A transfers on any edge with a_chipselect=1 and a_waitrequest=0;
  // a_readdatavalid answers each accepted read exactly once, LAT cycles later.
  assign a_waitrequest = fill_busy;
  assign a_in_range    = {1'b0, a_address} < DEPTH_L;
  assign b_in_range    = {1'b0, b_address} < DEPTH_L;
  assign a_accept      = a_chipselect & ~a_waitrequest;
  assign a_wr          = a_accept & a_write & a_in_range;
  assign a_rd          = a_accept & a_read & ~a_write;
  assign fill_run      = (state == FILL_RUN);

  // Fill engine owns the write port while running; reset blocks any write.
  assign ram_we    = reset_n & (fill_run | a_wr);
  assign ram_re    = a_rd & a_in_range;
  assign ram_be    = fill_run ? '1 : a_byteenable;
  assign ram_addr  = fill_run ? cnt : a_address;
  assign ram_wdata = fill_run ? fill_val : a_writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_pipe <= '0;
      roor_pipe   <= '0;
      boor_pipe   <= '0;
    end else begin
      rvalid_pipe <= LAT'({rvalid_pipe, a_rd});
      roor_pipe   <= LAT'({roor_pipe, ~a_in_range});
      if (b_clken) boor_pipe <= LAT'({boor_pipe, ~b_in_range});
    end
  end

  assign a_readdatavalid = rvalid_pipe[LAT-1];
  assign a_readdata      = roor_pipe[LAT-1] ? '0 : ram_a_rdata;
  assign b_readdata      = boor_pipe[LAT-1] ? '0 : ram_b_rdata;

  soc_textbuf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .OUT_REG(OUT_REG)
  ) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .a_we   (ram_we),
    .a_re   (ram_re),
    .a_be   (ram_be),
    .a_addr (ram_addr),
    .a_wdata(ram_wdata),
    .a_rdata(ram_a_rdata),
    .b_en   (b_clken),
    .b_addr (b_address),
    .b_rdata(ram_b_rdata)
  );

endmodule

// File: tb/tb_soc_textbuf_dpram.sv
// Directed bench: u0 is a small OUT_REG=0 buffer (16 words, 5-bit address),
// u1 is a 3000-word OUT_REG=1 buffer.
`timescale 1ns/1ps
module tb_soc_textbuf_dpram;
  import soc_textbuf_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n, rst1_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] model0 [16];
  int nw, nd, nbad, dpos;

  logic [4:0]  p0_addr, p0_baddr;
  logic        p0_cs, p0_rd, p0_wr, p0_rvalid, p0_wait, p0_bclken;
  logic [1:0]  p0_be;
  logic [15:0] p0_wdata, p0_rdata, p0_bdata, p0_fval;
  logic        p0_fstart, p0_busy, p0_done;
  fill_state_t p0_state;

  logic [11:0] p1_addr, p1_baddr;
  logic        p1_cs, p1_rd, p1_wr, p1_rvalid, p1_wait, p1_bclken;
  logic [1:0]  p1_be;
  logic [15:0] p1_wdata, p1_rdata, p1_bdata, p1_fval;
  logic        p1_fstart, p1_busy, p1_done;
  fill_state_t p1_state;

  soc_textbuf_dpram #(.DATA_W(16), .DEPTH(16), .ADDR_W(5), .OUT_REG(0)) u0 (
    .clk(clk), .reset_n(rst0_n), .a_address(p0_addr), .a_chipselect(p0_cs),
    .a_read(p0_rd), .a_write(p0_wr), .a_byteenable(p0_be), .a_writedata(p0_wdata),
    .a_readdata(p0_rdata), .a_readdatavalid(p0_rvalid), .a_waitrequest(p0_wait),
    .b_address(p0_baddr), .b_clken(p0_bclken), .b_readdata(p0_bdata),
    .fill_start(p0_fstart), .fill_value(p0_fval), .fill_busy(p0_busy),
    .fill_done(p0_done), .fill_state(p0_state)
  );

  soc_textbuf_dpram #(.DATA_W(16), .DEPTH(3000), .ADDR_W(12), .OUT_REG(1)) u1 (
    .clk(clk), .reset_n(rst1_n), .a_address(p1_addr), .a_chipselect(p1_cs),
    .a_read(p1_rd), .a_write(p1_wr), .a_byteenable(p1_be), .a_writedata(p1_wdata),
    .a_readdata(p1_rdata), .a_readdatavalid(p1_rvalid), .a_waitrequest(p1_wait),
    .b_address(p1_baddr), .b_clken(p1_bclken), .b_readdata(p1_bdata),
    .fill_start(p1_fstart), .fill_value(p1_fval), .fill_busy(p1_busy),
    .fill_done(p1_done), .fill_state(p1_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: entered and left on a falling edge
  task automatic p0_write(input logic [4:0] addr, input logic [15:0] data, input logic [1:0] be);
    bit acc = 1'b0;
    p0_addr = addr; p0_wdata = data; p0_be = be; p0_cs = 1'b1; p0_wr = 1'b1; p0_rd = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = !p0_wait;
      @(negedge clk);
    end
    check("p0_write_accept", 32'(acc), 32'd1);
    p0_cs = 1'b0; p0_wr = 1'b0;
  endtask

  task automatic p0_read(input logic [4:0] addr, input logic [15:0] exp, input string tag);
    bit acc = 1'b0;
    int lat = 1;
    p0_addr = addr; p0_cs = 1'b1; p0_rd = 1'b1; p0_wr = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = !p0_wait;
      @(negedge clk);
    end
    p0_cs = 1'b0; p0_rd = 1'b0;
    while (!p0_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check(tag, 32'(p0_rdata), 32'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(p0_rvalid), 32'd0);
  endtask

  task automatic p1_write(input logic [11:0] addr, input logic [15:0] data, input logic [1:0] be);
    bit acc = 1'b0;
    p1_addr = addr; p1_wdata = data; p1_be = be; p1_cs = 1'b1; p1_wr = 1'b1; p1_rd = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = !p1_wait;
      @(negedge clk);
    end
    check("p1_write_accept", 32'(acc), 32'd1);
    p1_cs = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic p1_read(input logic [11:0] addr, input logic [15:0] exp, input string tag);
    bit acc = 1'b0;
    int lat = 1;
    p1_addr = addr; p1_cs = 1'b1; p1_rd = 1'b1; p1_wr = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = !p1_wait;
      @(negedge clk);
    end
    p1_cs = 1'b0; p1_rd = 1'b0;
    while (!p1_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check(tag, 32'(p1_rdata), 32'(exp));
  endtask

  // Back-to-back reads of all 16 words of u0; scoreboard pops on each valid.
  task automatic p0_burst(input string tag);
    int got = 0;
    int first = -1;
    int last = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          p0_addr = 5'(i); p0_cs = 1'b1; p0_rd = 1'b1; p0_wr = 1'b0;
          exp_q.push_back(32'(model0[i]));
          @(negedge clk);
        end
        p0_cs = 1'b0; p0_rd = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 16; c++) begin
          @(negedge clk);
          if (p0_rvalid) begin
            check(tag, 32'(p0_rdata), exp_q.pop_front());
            if (first < 0) first = c;
            last = c;
            got++;
          end
        end
      end
    join
    check({tag, "_count"}, 32'(got), 32'd16);
    check({tag, "_span"}, 32'(last - first), 32'd15);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    p0_addr = '0; p0_cs = 1'b0; p0_rd = 1'b0; p0_wr = 1'b0; p0_be = '0; p0_wdata = '0;
    p0_baddr = '0; p0_bclken = 1'b1; p0_fstart = 1'b0; p0_fval = '0;
    p1_addr = '0; p1_cs = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0; p1_be = '0; p1_wdata = '0;
    p1_baddr = '0; p1_bclken = 1'b1; p1_fstart = 1'b0; p1_fval = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_rvalid0", 32'(p0_rvalid), 32'd0);
    check("rst_wait0", 32'(p0_wait), 32'd0);
    check("rst_busy0", 32'(p0_busy), 32'd0);
    check("rst_done0", 32'(p0_done), 32'd0);
    check("rst_state0", 32'(p0_state), 32'(FILL_IDLE));
    check("rst_rvalid1", 32'(p1_rvalid), 32'd0);
    check("rst_wait1", 32'(p1_wait), 32'd0);
    check("rst_busy1", 32'(p1_busy), 32'd0);
    check("rst_done1", 32'(p1_done), 32'd0);
    check("rst_state1", 32'(p1_state), 32'(FILL_IDLE));
    check("rst_adata1", 32'(p1_rdata), 32'd0);
    check("rst_bdata1", 32'(p1_bdata), 32'd0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);

    // byte enables
    p0_write(5'd5, 16'hABCD, 2'b11);
    p0_write(5'd5, 16'h1234, 2'b01);
    p0_read(5'd5, 16'hAB34, "be_lo");
    p0_write(5'd6, 16'h1111, 2'b11);
    p0_write(5'd6, 16'h9900, 2'b10);
    p0_read(5'd6, 16'h9911, "be_hi");

    // write at edge t, read of the same word accepted at t+1
    p0_write(5'd3, 16'h5555, 2'b11);
    p0_read(5'd3, 16'h5555, "wr_then_rd");

    // read and write together: write only, no valid
    p0_addr = 5'd4; p0_wdata = 16'h7777; p0_be = 2'b11;
    p0_cs = 1'b1; p0_rd = 1'b1; p0_wr = 1'b1;
    @(negedge clk);
    p0_cs = 1'b0; p0_rd = 1'b0; p0_wr = 1'b0;
    nw = 0;
    repeat (3) begin
      if (p0_rvalid) nw++;
      @(negedge clk);
    end
    check("rw_no_valid", 32'(nw), 32'd0);
    p0_read(5'd4, 16'h7777, "rw_written");

    // out of range on u0: 20 would alias word 4 if not masked
    p0_write(5'd20, 16'hFFFF, 2'b11);
    p0_read(5'd20, 16'h0000, "oor_read0");
    p0_read(5'd4, 16'h7777, "oor_alias0");

    // port B on u0
    p0_baddr = 5'd5;
    @(negedge clk);
    check("b0_read", 32'(p0_bdata), 32'h0000AB34);
    p0_baddr = 5'd20;
    @(negedge clk);
    check("b0_oor", 32'(p0_bdata), 32'd0);

    // fill with a concurrent port A read and a write held during the fill
    for (int i = 0; i < 16; i++) model0[i] = 16'h0720;
    model0[9] = 16'hBEEF;
    p0_fstart = 1'b1; p0_fval = 16'h0720;
    fork
      p0_read(5'd5, 16'hAB34, "fill_start_rd");
      begin
        nw = 0; nd = 0; nbad = 0; dpos = -1;
        @(negedge clk);
        p0_fstart = 1'b0; p0_fval = 16'h0000;
        for (int c = 0; c < 30; c++) begin
          if (p0_wait) nw++;
          if (p0_done) begin nd++; dpos = c; end
          if (p0_busy !== p0_wait) nbad++;
          @(negedge clk);
        end
        check("fill_wait_cycles", 32'(nw), 32'd17);
        check("fill_done_pulses", 32'(nd), 32'd1);
        check("fill_done_pos", 32'(dpos), 32'd16);
        check("fill_busy_eq_wait", 32'(nbad), 32'd0);
      end
      begin
        repeat (3) @(negedge clk);
        p0_write(5'd9, 16'hBEEF, 2'b11);
      end
    join
    p0_burst("fill_verify");

    // reset at fill write 8; a second fill_start during FILL is ignored
    p0_fstart = 1'b1; p0_fval = 16'h1F1F;
    @(negedge clk);
    p0_fstart = 1'b0;
    repeat (2) @(negedge clk);
    check("midfill_busy", 32'(p0_busy), 32'd1);
    p0_fstart = 1'b1; p0_fval = 16'h2222;
    @(negedge clk);
    p0_fstart = 1'b0; p0_fval = 16'h0000;
    repeat (5) @(negedge clk);
    rst0_n = 1'b0;
    @(negedge clk);
    check("mrst_wait", 32'(p0_wait), 32'd0);
    check("mrst_busy", 32'(p0_busy), 32'd0);
    check("mrst_done", 32'(p0_done), 32'd0);
    check("mrst_rvalid", 32'(p0_rvalid), 32'd0);
    check("mrst_state", 32'(p0_state), 32'(FILL_IDLE));
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(p0_state), 32'(FILL_IDLE));
    for (int i = 0; i < 8; i++) model0[i] = 16'h1F1F;
    p0_burst("partial_fill");

    // collision on u1: port B sees old data, then new
    p1_write(12'd7, 16'h0041, 2'b11);
    p1_baddr = 12'd7; p1_bclken = 1'b1;
    p1_write(12'd7, 16'h0042, 2'b11);
    @(negedge clk);
    check("coll_old", 32'(p1_bdata), 32'h0041);
    @(negedge clk);
    check("coll_new", 32'(p1_bdata), 32'h0042);
    p1_read(12'd7, 16'h0042, "p1_read");

    // out of range on u1
    p1_write(12'd3500, 16'hDEAD, 2'b11);
    p1_read(12'd3500, 16'h0000, "oor_read1");
    p1_baddr = 12'd3500;
    repeat (2) @(negedge clk);
    check("b1_oor", 32'(p1_bdata), 32'd0);

    // port B stall with a sample still in the pipeline
    p1_write(12'd10, 16'h1010, 2'b11);
    p1_write(12'd11, 16'h1111, 2'b11);
    p1_baddr = 12'd10;
    repeat (3) @(negedge clk);
    check("stall_pre", 32'(p1_bdata), 32'h1010);
    p1_baddr = 12'd11;
    @(negedge clk);
    p1_bclken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p1_baddr = 12'(20 + i);
      @(negedge clk);
      check("stall_hold", 32'(p1_bdata), 32'h1010);
    end
    p1_baddr = 12'd10; p1_bclken = 1'b1;
    @(negedge clk);
    check("stall_resume1", 32'(p1_bdata), 32'h1111);
    @(negedge clk);
    check("stall_resume2", 32'(p1_bdata), 32'h1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_textbuf_dpram.md
# soc_textbuf_dpram

Parametrised dual-port on-chip buffer for the VGA text-mode path. It replaces the fixed 4096×8 character RAM: data width and depth are configurable, the output register is optional, and there are byte enables. Port A is an Avalon-MM slave for the HPS/Nios side. Port B is a read-only scanout port for the character generator. A built-in fill engine clears or fills the whole buffer in hardware.

## Interface
- `DATA_W`, default 16: word width (char + attribute); must be a multiple of 8.
- `DEPTH`, default 4096: number of words; 2 ≤ `DEPTH` ≤ 2**`ADDR_W`.
- `ADDR_W`, default 12: address width for both ports.
- `OUT_REG`, default 0: 1 adds an output register on both ports.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_address` in `ADDR_W`: port A word address.
- `a_chipselect`, `a_read`, `a_write` in 1: Avalon-MM controls.
- `a_byteenable` in `DATA_W/8`: per-byte write enable.
- `a_writedata` in `DATA_W`: write data.
- `a_readdata` out `DATA_W`: read data.
- `a_readdatavalid` out 1: qualifies `a_readdata`.
- `a_waitrequest` out 1: high while the fill engine runs.
- `b_address` in `ADDR_W`: scanout address.
- `b_clken` in 1: low stalls the port B address and holds `b_readdata`.
- `b_readdata` out `DATA_W`: scanout data.
- `fill_start` in 1: one-cycle request to start a fill.
- `fill_value` in `DATA_W`: fill word, sampled with `fill_start`.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse when a fill completes.

## Operation
- **Port A accept.** A transfer is accepted when `a_chipselect` is high and `a_waitrequest` is low.
- **Port A writes.** An accepted write updates only the bytes whose `a_byteenable` bit is 1.
- **Read and write together.** `a_read` and `a_write` high in the same cycle is treated as a write only. No `a_readdatavalid` is returned.
- **Out-of-range addresses (≥ `DEPTH`).** Writes are dropped. Reads return 0 with `a_readdatavalid` high. Port B returns 0.
- **Port B.** Read-only. It samples `b_address` on every cycle where `b_clken` is 1.
- **Mixed-port collision.** Port B reading the address that port A or the fill engine writes in the same cycle gets OLD data.
- **Fill FSM, IDLE.** `fill_start` loads `fill_value`, clears the counter and moves to FILL.
- **Fill FSM, FILL.** Writes `fill_value` to address `cnt` with all bytes enabled, then increments `cnt`. When `cnt == DEPTH-1` has been written, moves to DONE.
- **Fill FSM, DONE.** Pulses `fill_done` for one cycle, then returns to IDLE.
- **`fill_start` outside IDLE.** Ignored.
- **`fill_busy`.** High in FILL and DONE.
- **`a_waitrequest`.** Equals `fill_busy`. Port A is never granted while the fill engine owns the write port. Port B keeps reading throughout.
- **`fill_start` in the same cycle as an accepted port A access (IDLE).** The port A access completes. The fill begins its first write on the next cycle.
- **Reset behaviour.**
  - FSM returns to IDLE; counter and pipelines clear.
  - Memory contents are NOT cleared, so a fill interrupted by reset leaves the buffer partially filled.
  - Reads in flight are discarded, with no `a_readdatavalid`.
- **Reset values.**
  - `a_readdatavalid`, `a_waitrequest`, `fill_busy`, `fill_done` = 0.
  - With `OUT_REG`=1: `a_readdata` and `b_readdata` = 0.
  - With `OUT_REG`=0: both are undefined until the first read. `a_readdata` is qualified by `a_readdatavalid`.

## Timing
- **Port A read latency.** 1+`OUT_REG` cycles: a read accepted at edge t gives `a_readdatavalid` high at t+1+`OUT_REG` for exactly one cycle.
- **Port A throughput.** Back-to-back reads give one valid per cycle.
- **Port A write.** The write takes effect at the accepting edge. A read of the same address accepted on the next cycle returns the new data.
- **Port B latency.** 1+`OUT_REG` cycles from the `b_clken`=1 sample.
- **Port B stall.** With `b_clken`=0 the captured address and `b_readdata` hold.
- **Fill duration.** `fill_start` at edge t:
  - `fill_busy` high from t+1.
  - Writes occur at edges t+1 … t+`DEPTH`.
  - `fill_done` pulses in cycle t+`DEPTH`+1.
  - `a_waitrequest` falls at t+`DEPTH`+2.

## Structure
- **Shared package `soc_textbuf_pkg`.** Holds:
  - the fill FSM state enum (`FILL_IDLE`, `FILL_RUN`, `FILL_DONE`);
  - a `BE_W` = `DATA_W/8` helper function;
  - the latency constant expression 1+`OUT_REG`.
- **Sub-module `soc_textbuf_ram`.** Inferred true dual-port RAM with byte-enable on port A, read-only port B, OLD_DATA mixed-port behaviour and optional output register.
- **Top level.** Holds the write-port mux (fill engine vs port A), the FSM, the valid pipeline and the out-of-range masking.

## Test plan
- **Byte-enable write, then read (`DATA_W`=16, `OUT_REG`=0).** Write 0xABCD to addr 5 with be=11, then write 0x1234 with be=01. Read addr 5 → 0xAB34, `a_readdatavalid` one cycle after accept.
- **Collision (`OUT_REG`=1).** Addr 7 holds 0x0041. Port A writes 0x0042 to addr 7 while port B reads addr 7 in the same cycle. Port B returns 0x0041 two cycles later; the next port B read returns 0x0042.
- **Fill (`DEPTH`=16).** Pulse `fill_start` with `fill_value`=0x0720.
  - `a_waitrequest` is high for 17 cycles; `fill_done` pulses once.
  - Every address reads 0x0720.
  - A port A write held during the fill completes only after `a_waitrequest` falls.
- **Reset mid-fill.** Drive `reset_n` low at fill write 8 of 16. Addrs 0–7 = fill value, addrs 8–15 unchanged; all outputs at reset values; a `fill_start` during FILL has no effect.
- **Out of range and stall (`DEPTH`=3000).** Write to addr 3500 is dropped; a read of addr 3500 returns 0 with valid. With `b_clken` held low for 5 cycles, `b_readdata` stays constant while `b_address` changes.
